// File: rtl/mem2_stage.sv
// Registered MEM2 stage: holds one entry, waits for RAM read data on loads and
// formats it (lane select + extension). Optional MEM2_MISALIGN_TRAP_EN flags misaligned loads.
module mem2_stage #(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] rd_data_in,
    input  logic [OFFW-1:0] addr_lo_in,
    input  logic            ram_rvalid,
    input  logic [XLEN-1:0] ram_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rd_we_out,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] rd_data_out,
    output logic            exc_out
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_D  = 3'b011;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;
    localparam logic [2:0] FUNCT3_WU = 3'b110;

    typedef enum logic [1:0] {EMPTY, WAIT_RAM, FULL} state_t;

    state_t          state, state_next;
    logic            accept, is_load, ram_take;
    logic [2:0]      ld_funct3;
    logic [4:0]      ld_rd_addr;
    logic [OFFW-1:0] ld_addr_lo;
    logic [OFFW-1:0] align_mask, aligned_off;
    logic [XLEN-1:0] lane, fmt_data, load_data;
    logic            fmt_ok, load_we;

    assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready);
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign is_load   = (opcode_in == OPC_LOAD);
    assign ram_take  = (state == WAIT_RAM) && ram_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:    if (accept) state_next = is_load ? WAIT_RAM : FULL;
                WAIT_RAM: if (ram_rvalid) state_next = FULL;
                FULL: begin
                    if (out_ready) begin
                        if (accept) state_next = is_load ? WAIT_RAM : FULL;
                        else        state_next = EMPTY;
                    end
                end
                default:  state_next = EMPTY;
            endcase
        end
    end

    // The access size is 1 << funct3[1:0] bytes; clearing the low offset bits
    // aligns the lane to it (and truncates misaligned offsets when not trapping).
    always_comb begin
        align_mask  = {OFFW{1'b1}} << ld_funct3[1:0];
        aligned_off = ld_addr_lo & align_mask;
        lane        = ram_data >> {aligned_off, 3'b000};
        fmt_data    = '0;
        fmt_ok      = 1'b1;
        case (ld_funct3)
            FUNCT3_B:  fmt_data = XLEN'($signed(lane[7:0]));
            FUNCT3_BU: fmt_data = XLEN'(lane[7:0]);
            FUNCT3_H:  fmt_data = XLEN'($signed(lane[15:0]));
            FUNCT3_HU: fmt_data = XLEN'(lane[15:0]);
            FUNCT3_W:  fmt_data = XLEN'($signed(lane[31:0]));
            FUNCT3_WU: begin
                if (XLEN == 64) fmt_data = XLEN'(lane[31:0]);
                else            fmt_ok   = 1'b0;
            end
            FUNCT3_D: begin
                if (XLEN == 64) fmt_data = lane;
                else            fmt_ok   = 1'b0;
            end
            default:   fmt_ok = 1'b0;
        endcase
    end

`ifdef MEM2_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = fmt_ok && (|(ld_addr_lo & ~align_mask));
    assign load_we    = !misaligned;
    assign load_data  = (fmt_ok && !misaligned) ? fmt_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_out <= 1'b0;
        end else if (!flush) begin
            if (ram_take)                 exc_out <= misaligned;
            else if (accept && !is_load)  exc_out <= 1'b0;
        end
    end
`else
    assign exc_out   = 1'b0;
    assign load_we   = 1'b1;
    assign load_data = fmt_ok ? fmt_data : '0;
`endif

    // Result and pending-load registers; flush drops both the accept and the RAM return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we_out   <= 1'b0;
            rd_addr_out <= '0;
            rd_data_out <= '0;
            ld_funct3   <= '0;
            ld_rd_addr  <= '0;
            ld_addr_lo  <= '0;
        end else if (!flush) begin
            if (ram_take) begin
                rd_we_out   <= load_we;
                rd_addr_out <= ld_rd_addr;
                rd_data_out <= load_data;
            end else if (accept) begin
                if (is_load) begin
                    ld_funct3  <= funct3_in;
                    ld_rd_addr <= rd_addr_in;
                    ld_addr_lo <= addr_lo_in;
                end else begin
                    rd_we_out   <= !((opcode_in == OPC_BRANCH) || (opcode_in == OPC_STORE));
                    rd_addr_out <= rd_addr_in;
                    rd_data_out <= rd_data_in;
                end
            end
        end
    end

endmodule

// File: doc/mem2_stage.md
Name: mem2_stage

Overview:
- Registered MEM2/writeback-prep stage; successor to the combinational load formatter.
- Parametrised in datapath width (RV32/RV64).
- Extracts load byte lanes using the low address bits, then sign- or zero-extends the result.
- Single-entry buffer with valid/ready handshakes on both sides; waits for variable-latency RAM read data. Feeds the register-file write port.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OFFW, $clog2(XLEN/8), width of the address byte-offset field (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- opcode_in  in  7  instruction opcode.
- funct3_in  in  3  instruction funct3.
- rd_addr_in  in  5  destination register.
- rd_data_in  in  XLEN  ALU result for non-loads.
- addr_lo_in  in  OFFW  low bits of the effective address.
- ram_rvalid  in  1  RAM read data valid.
- ram_data  in  XLEN  RAM read word (naturally aligned).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- rd_we_out  out  1  register-file write enable.
- rd_addr_out  out  5  destination register.
- rd_data_out  out  XLEN  writeback data.
- exc_out  out  1  misaligned-load exception (see Optional Feature).

Behaviour:
- Reset (rst high, asynchronous):
  - state=EMPTY.
  - out_valid=0, rd_we_out=0, rd_addr_out=0, rd_data_out=0, exc_out=0.
- States: EMPTY, WAIT_RAM, FULL.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). Combinational; never depends on in_valid.
- Accept = in_valid & in_ready:
  - opcode==OPC_LOAD: capture opcode, funct3, rd_addr and addr_lo; go to WAIT_RAM.
  - Otherwise: register the result immediately; go to FULL. Latency is 1 cycle from accept to out_valid.
- WAIT_RAM:
  - out_valid=0 and in_ready=0.
  - On ram_rvalid: format the data and register it; go to FULL. out_valid rises the cycle after ram_rvalid.
- ram_rvalid outside WAIT_RAM is ignored. RAM data is never valid in the accept cycle.
- FULL:
  - Outputs are held stable while out_ready=0.
  - On out_ready: go to EMPTY, or take the new accepted entry (back-to-back throughput of 1 per cycle for non-loads).
- rd_we_out = 0 for OPC_BRANCH or OPC_STORE; 1 otherwise.
- Non-load: rd_data_out = rd_data_in.
- Load lane select: lane = ram_data >> (8*addr_lo), with addr_lo aligned to the access size.
- Load width and extension by funct3 (funct3[2]=1 means zero-extend, otherwise sign-extend):
  - FUNCT3_B: lane[7:0], extended by funct3[2].
  - FUNCT3_H: lane[15:0], extended by funct3[2].
  - FUNCT3_W: when XLEN=32, the full word. When XLEN=64, lane[31:0], sign-extended (LW) or zero-extended (LWU, funct3=110).
  - funct3=011 (LD): only when XLEN=64; full word.
- Unsupported funct3 (011/110 when XLEN=32, 111 always): rd_data_out=0, rd_we_out=1.
- flush:
  - Forces state=EMPTY and out_valid=0 on the next edge.
  - Discards the entry in WAIT_RAM; a later ram_rvalid is ignored.
  - Has priority over accept and over ram_rvalid. in_ready is still computed normally during flush, but the accept is dropped.
- Simultaneous FULL & out_ready & in_valid: the old result retires and the new entry is taken in the same edge.
- Reset mid-load: the entry is lost; no output is produced.

Optional Feature:
- Macro: MEM2_MISALIGN_TRAP_EN.
- Defined:
  - A load whose addr_lo is not aligned to its access size (H: bit0≠0; W: [1:0]≠0; D: [2:0]≠0) still waits for ram_rvalid.
  - The result then has exc_out=1, rd_we_out=0, rd_data_out=0.
  - exc_out is valid only with out_valid.
- Undefined:
  - exc_out tied to 0.
  - Misaligned offsets are truncated to natural alignment (low bits ignored); the load completes normally.

Test Plan:
- XLEN=32, LB funct3=000, addr_lo=2, ram_data=0x1280_3456 → rd_data_out=0xFFFF_FF80, rd_we_out=1.
- XLEN=32, LHU funct3=101, addr_lo=2, ram_data=0x8001_0000 → rd_data_out=0x0000_8001. Also check: out_valid rises 1 cycle after ram_rvalid, which is driven 3 cycles after accept.
- STORE then BRANCH back-to-back, out_ready=1 → each out_valid 1 cycle after accept, rd_we_out=0, one result per cycle.
- Non-load in FULL with out_ready=0 for 4 cycles → outputs stable, in_ready=0. Raising out_ready with in_valid=1 → retire and accept in the same cycle.
- XLEN=64, LWU funct3=110, addr_lo=4, ram_data=0xF000_0001_0000_0000 → 0x0000_0000_F000_0001. LW with the same inputs → 0xFFFF_FFFF_F000_0001.
- Load in WAIT_RAM, flush, then ram_rvalid → no out_valid, state EMPTY. With MEM2_MISALIGN_TRAP_EN, LW addr_lo=1 → exc_out=1, rd_we_out=0.
